// File: rtl/fir_filter_mc_pkg.sv
// Shared FSM state type and sizing helpers for the multi-channel FIR filter.
package fir_filter_mc_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MAC   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + clog2_min1(taps);
  endfunction

  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/fir_delay_ram.sv
// Simple dual-port delay-line memory: one write port, one read port with 1-cycle latency.
module fir_delay_ram
  import fir_filter_mc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [clog2_min1(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W-1:0]              wdata_i,
  input  logic [clog2_min1(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]              rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR: one MAC per clock, shared runtime-loadable
// coefficients, per-channel circular delay lines in a single RAM.
module fir_filter_mc
  import fir_filter_mc_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned TAPS     = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SHIFT    = 15
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              call_valid,
  output logic                              call_stall,
  input  logic [DATA_W-1:0]                 call_data,
  input  logic [clog2_min1(CHANNELS)-1:0]   call_chan,
  output logic                              return_valid,
  input  logic                              return_stall,
  output logic [OUT_W-1:0]                  return_data,
  output logic [clog2_min1(CHANNELS)-1:0]   return_chan,
  input  logic                              coef_we,
  input  logic [clog2_min1(TAPS)-1:0]       coef_addr,
  input  logic [COEF_W-1:0]                 coef_data,
  output logic                              coef_busy
);

  localparam int unsigned CH_W   = clog2_min1(CHANNELS);
  localparam int unsigned TAP_W  = clog2_min1(TAPS);
  localparam int unsigned DEPTH  = CHANNELS * TAPS;
  localparam int unsigned ADDR_W = clog2_min1(DEPTH);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(OUT_W));

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         clr_addr_q, clr_addr_d;
  logic [TAP_W-1:0]          tap_q, tap_d, rd_idx_q, rd_idx_d;
  logic [CH_W-1:0]           chan_q, chan_d;
  logic                      chan_ok_q, chan_ok_d;
  logic signed [DATA_W-1:0]  samp_q, samp_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [TAP_W-1:0]          ptr_q [CHANNELS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];

  logic                      call_stall_q, call_stall_d;
  logic                      coef_busy_q, coef_busy_d;
  logic                      return_valid_q, return_valid_d;
  logic [OUT_W-1:0]          return_data_q, return_data_d;
  logic [CH_W-1:0]           return_chan_q, return_chan_d;

  logic                      ram_we_c;
  logic [ADDR_W-1:0]         ram_waddr_c, ram_raddr_c;
  logic [DATA_W-1:0]         ram_wdata_c, ram_rdata;
  logic                      coef_wr_c, ptr_adv_c, call_ok_c;
  logic [CH_W-1:0]           call_sel_c, chan_cur_c;
  logic [TAP_W-1:0]          ptr_cur_c, ptr_nxt_c;
  logic signed [DATA_W-1:0]  tap_x_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [ACC_W-1:0]   acc_sum_c, shifted_c;
  logic [OUT_W-1:0]          sat_c;

  function automatic logic [TAP_W-1:0] idx_dec(input logic [TAP_W-1:0] i);
    return (i == '0) ? TAP_W'(TAPS - 1) : i - TAP_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [CH_W-1:0] ch,
                                                  input logic [TAP_W-1:0] idx);
    return ADDR_W'(ch) * ADDR_W'(TAPS) + ADDR_W'(idx);
  endfunction

  fir_delay_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we_c),
    .waddr_i (ram_waddr_c),
    .wdata_i (ram_wdata_c),
    .raddr_i (ram_raddr_c),
    .rdata_o (ram_rdata)
  );

  // Datapath: tap 0 bypasses the latched sample, later taps come from the RAM read issued a cycle earlier.
  always_comb begin
    call_ok_c   = 32'(call_chan) < CHANNELS;
    call_sel_c  = call_ok_c ? call_chan : '0;
    chan_cur_c  = chan_ok_q ? chan_q : '0;
    ptr_cur_c   = ptr_q[chan_cur_c];
    ptr_nxt_c   = (ptr_cur_c == TAP_W'(TAPS - 1)) ? '0 : ptr_cur_c + TAP_W'(1);
    ram_raddr_c = word_addr(chan_cur_c, rd_idx_q);
    tap_x_c     = (tap_q == '0) ? samp_q : $signed(ram_rdata);
    prod_c      = PROD_W'(tap_x_c) * PROD_W'(coef_q[tap_q]);
    acc_sum_c   = acc_q + (chan_ok_q ? ACC_W'(prod_c) : '0);
    shifted_c   = acc_sum_c >>> SHIFT;
    if (shifted_c > ACC_MAX)      sat_c = OUT_W'(ACC_MAX);
    else if (shifted_c < ACC_MIN) sat_c = OUT_W'(ACC_MIN);
    else                          sat_c = OUT_W'(shifted_c);
  end

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    tap_d         = tap_q;
    rd_idx_d      = rd_idx_q;
    chan_d        = chan_q;
    chan_ok_d     = chan_ok_q;
    samp_d        = samp_q;
    acc_d         = acc_q;
    return_data_d = return_data_q;
    return_chan_d = return_chan_q;
    ram_we_c      = 1'b0;
    ram_waddr_c   = '0;
    ram_wdata_c   = '0;
    coef_wr_c     = 1'b0;
    ptr_adv_c     = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        ram_we_c    = 1'b1;
        ram_waddr_c = clr_addr_q;
        clr_addr_d  = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        coef_wr_c = coef_we && (32'(coef_addr) < TAPS);
        if (call_valid) begin
          chan_d      = call_chan;
          chan_ok_d   = call_ok_c;
          samp_d      = $signed(call_data);
          ram_we_c    = call_ok_c;
          ram_waddr_c = word_addr(call_sel_c, ptr_q[call_sel_c]);
          ram_wdata_c = call_data;
          rd_idx_d    = idx_dec(ptr_q[call_sel_c]);
          tap_d       = '0;
          acc_d       = '0;
          state_d     = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d    = acc_sum_c;
        rd_idx_d = idx_dec(rd_idx_q);
        tap_d    = tap_q + TAP_W'(1);
        if (tap_q == TAP_W'(TAPS - 1)) begin
          ptr_adv_c     = chan_ok_q;
          return_data_d = sat_c;
          return_chan_d = chan_q;
          state_d       = ST_OUT;
        end
      end
      ST_OUT: begin
        if (!return_stall) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
    call_stall_d   = (state_d != ST_IDLE);
    coef_busy_d    = (state_d != ST_IDLE);
    return_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_CLEAR;
      clr_addr_q     <= '0;
      tap_q          <= '0;
      rd_idx_q       <= '0;
      chan_q         <= '0;
      chan_ok_q      <= 1'b0;
      samp_q         <= '0;
      acc_q          <= '0;
      call_stall_q   <= 1'b1;
      coef_busy_q    <= 1'b1;
      return_valid_q <= 1'b0;
      return_data_q  <= '0;
      return_chan_q  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) ptr_q[i] <= '0;
      for (int unsigned i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      clr_addr_q     <= clr_addr_d;
      tap_q          <= tap_d;
      rd_idx_q       <= rd_idx_d;
      chan_q         <= chan_d;
      chan_ok_q      <= chan_ok_d;
      samp_q         <= samp_d;
      acc_q          <= acc_d;
      call_stall_q   <= call_stall_d;
      coef_busy_q    <= coef_busy_d;
      return_valid_q <= return_valid_d;
      return_data_q  <= return_data_d;
      return_chan_q  <= return_chan_d;
      if (coef_wr_c) coef_q[coef_addr] <= $signed(coef_data);
      if (ptr_adv_c) ptr_q[chan_cur_c] <= ptr_nxt_c;
    end
  end

  assign call_stall   = call_stall_q;
  assign coef_busy    = coef_busy_q;
  assign return_valid = return_valid_q;
  assign return_data  = return_data_q;
  assign return_chan  = return_chan_q;

endmodule

// File: tb/tb_fir_filter_mc.sv
// Directed bench for fir_filter_mc with a shift-register reference model and literal result lists.
module tb_fir_filter_mc;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned TAPS     = 4;
  localparam int unsigned CHANNELS = 3;
  localparam int unsigned SHIFT    = 0;
  localparam int unsigned CH_W     = 2;
  localparam int unsigned TAP_W    = 2;
  localparam int          LIMIT    = 200;

  logic              clk = 1'b0;
  logic              reset;
  logic              call_valid;
  logic              call_stall;
  logic [DATA_W-1:0] call_data;
  logic [CH_W-1:0]   call_chan;
  logic              return_valid;
  logic              return_stall;
  logic [OUT_W-1:0]  return_data;
  logic [CH_W-1:0]   return_chan;
  logic              coef_we;
  logic [TAP_W-1:0]  coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              coef_busy;

  always #5 clk = ~clk;

  fir_filter_mc #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W),
    .TAPS(TAPS), .CHANNELS(CHANNELS), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .reset(reset),
    .call_valid(call_valid), .call_stall(call_stall), .call_data(call_data), .call_chan(call_chan),
    .return_valid(return_valid), .return_stall(return_stall), .return_data(return_data),
    .return_chan(return_chan),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: newest sample at hist_m[ch][0], plain sum of products.
  typedef struct {
    longint data;
    longint chan;
    int     acc_n;
  } exp_t;

  longint coef_m [TAPS];
  longint hist_m [CHANNELS][TAPS];
  exp_t   exp_q[$];
  longint got_q[$];
  bit     seen_first = 1'b0;
  int     ncyc = 0;

  always @(negedge clk) begin
    longint acc;
    exp_t   e;
    ncyc++;
    if (reset) begin
      for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS; k++) hist_m[c][k] = 0;
      exp_q.delete();
      seen_first = 1'b0;
    end else begin
      if (return_valid) begin
        check("pending_on_valid", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          if (!seen_first) begin
            check("latency", longint'(ncyc - exp_q[0].acc_n), TAPS + 1);
            seen_first = 1'b1;
          end
          check("return_data", longint'($signed(return_data)), exp_q[0].data);
          check("return_chan", longint'(return_chan), exp_q[0].chan);
          check("call_stall_in_out", longint'(call_stall), 1);
          if (!return_stall) begin
            got_q.push_back(longint'($signed(return_data)));
            void'(exp_q.pop_front());
            seen_first = 1'b0;
          end
        end
      end
      if (coef_we && !coef_busy) coef_m[coef_addr] = longint'($signed(coef_data));
      if (call_valid && !call_stall) begin
        acc = 0;
        if (call_chan < CHANNELS) begin
          for (int k = TAPS - 1; k > 0; k--) hist_m[call_chan][k] = hist_m[call_chan][k-1];
          hist_m[call_chan][0] = longint'($signed(call_data));
          for (int k = 0; k < TAPS; k++) acc += hist_m[call_chan][k] * coef_m[k];
          acc = acc >>> SHIFT;
          if (acc > 32767) acc = 32767;
          if (acc < -32768) acc = -32768;
        end
        e.data  = acc;
        e.chan  = longint'(call_chan);
        e.acc_n = ncyc;
        exp_q.push_back(e);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(posedge clk); #1;
    while (call_stall !== 1'b0 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= LIMIT) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: still stalled after %0d cycles, required fewer than %0d", n, LIMIT);
    end
  endtask

  task automatic issue(input bit do_call, input int ch, input longint x,
                       input bit do_coef, input int ca, input longint cd);
    wait_ready();
    call_valid = do_call;
    call_chan  = CH_W'(ch);
    call_data  = DATA_W'(x);
    coef_we    = do_coef;
    coef_addr  = TAP_W'(ca);
    coef_data  = COEF_W'(cd);
    @(posedge clk); #1;
    call_valid = 1'b0;
    coef_we    = 1'b0;
  endtask

  task automatic send(input int ch, input longint x);
    issue(1'b1, ch, x, 1'b0, 0, 0);
  endtask

  task automatic wcoef(input int ca, input longint cd);
    issue(1'b0, 0, 0, 1'b1, ca, cd);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || return_valid) && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= LIMIT) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: results pending after %0d cycles, required fewer than %0d", n, LIMIT);
    end
  endtask

  task automatic expect_got(input string name, input longint vals[$]);
    check({name, "_count"}, longint'(got_q.size()), longint'(vals.size()));
    for (int i = 0; i < vals.size(); i++)
      if (i < got_q.size()) check($sformatf("%s[%0d]", name, i), got_q[i], vals[i]);
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    longint e[$];
    int     n;
    reset = 1'b1; call_valid = 1'b0; call_data = '0; call_chan = '0;
    return_stall = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Clear phase length and reset-valued outputs
    n = 0;
    @(negedge clk);
    while (call_stall === 1'b1 && n < LIMIT) begin
      check("clear_coef_busy", longint'(coef_busy), 1);
      check("clear_return_valid", longint'(return_valid), 0);
      check("clear_return_data", longint'(return_data), 0);
      check("clear_return_chan", longint'(return_chan), 0);
      n++;
      @(negedge clk);
    end
    check("clear_cycles", n, CHANNELS * TAPS);
    check("coef_busy_after_clear", longint'(coef_busy), 0);

    // Impulse on ch0, five samples exercise the pointer wrap
    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
    got_q.delete();
    send(0, 1); send(0, 0); send(0, 0); send(0, 0); send(0, 0);
    wait_drain();
    e = '{1, 2, 3, 4, 0};
    expect_got("impulse", e);

    // Interleaved ch0 impulse and ch1 constant
    send(0, 1); send(1, 2); send(0, 0); send(1, 2); send(0, 0); send(1, 2);
    send(0, 0); send(1, 2); send(1, 2);
    wait_drain();
    e = '{1, 2, 2, 6, 3, 12, 4, 20, 20};
    expect_got("interleave", e);

    // Coefficient write during MAC is ignored
    send(2, 1);
    check("coef_busy_in_mac", longint'(coef_busy), 1);
    coef_we = 1'b1; coef_addr = '0; coef_data = 16'd100;
    @(posedge clk); #1 coef_we = 1'b0;
    wait_drain();
    e = '{1};
    expect_got("busy_write", e);

    // Coefficient write and sample accepted together: new coefficient applies
    issue(1'b1, 2, 0, 1'b1, 1, 10);
    wait_drain();
    e = '{10};
    expect_got("same_cycle_coef", e);

    // Out-of-range channel returns zero
    send(3, 5);
    wait_drain();
    e = '{0};
    expect_got("bad_chan", e);

    // Backpressure: output held while downstream stalls
    return_stall = 1'b1;
    send(1, 1);
    n = 0;
    while (!return_valid && n < LIMIT) begin @(posedge clk); #1; n++; end
    repeat (10) @(posedge clk);
    #1;
    check("bp_valid_held", longint'(return_valid), 1);
    check("bp_data_held", longint'($signed(return_data)), 35);
    check("bp_call_stall", longint'(call_stall), 1);
    return_stall = 1'b0;
    wait_drain();
    check("bp_idle_after", longint'(call_stall), 0);
    e = '{35};
    expect_got("backpressure", e);

    // Saturation both directions
    for (int k = 0; k < TAPS; k++) wcoef(k, 32767);
    send(2, 32767);
    send(0, -32768);
    wait_drain();
    e = '{32767, -32768};
    expect_got("saturate", e);

    // Reset mid-MAC discards the result and zeroes coefficients
    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
    send(0, 1);
    coef_we = 1'b1; coef_addr = '0; coef_data = 16'd7;
    @(posedge clk); #1 coef_we = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_call_stall", longint'(call_stall), 1);
    check("rst_return_valid", longint'(return_valid), 0);
    got_q.delete();
    send(0, 1);
    wait_drain();
    e = '{0};
    expect_got("after_reset", e);

    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
    send(1, 1); send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    wait_drain();
    e = '{1, 2, 3, 4, 0};
    expect_got("impulse_after_reset", e);

    check("final_pending", longint'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
